// File: rtl/cache_bus1_responder.sv
// Cache-side responder for CPU<->cache bus 1: decodes the two-cycle command/address
// phase, serves reads/writes from a byte store and answers after a fixed latency.
module cache_bus1_responder #(
  parameter int unsigned LATENCY       = 6,
  parameter int unsigned MEM_ADDR_BITS = 18
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [13:0] A1,
  inout  wire  [15:0] D1,
  inout  wire  [2:0]  C1,
  output logic        BUSY,
  output logic [31:0] RD_COUNT,
  output logic [31:0] WR_COUNT
);

  localparam int AW = MEM_ADDR_BITS;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
  localparam logic [2:0] RESP_CODE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR2, S_WAIT, S_RESP0, S_RESP1, S_RELEASE
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_RD8, CMD_RD16, CMD_RD32, CMD_INV, CMD_WR8, CMD_WR16, CMD_WR32
  } cmd_e;

  function automatic logic is_read(input cmd_e c);
    return (c == CMD_RD8) || (c == CMD_RD16) || (c == CMD_RD32);
  endfunction

  function automatic logic is_write(input cmd_e c);
    return (c == CMD_WR8) || (c == CMD_WR16) || (c == CMD_WR32);
  endfunction

  // 16-bit accesses drop addr[0], 32-bit accesses drop addr[1:0].
  function automatic logic [AW-1:0] align(input cmd_e c, input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    if (c == CMD_RD16 || c == CMD_WR16) r[0] = 1'b0;
    if (c == CMD_RD32 || c == CMD_WR32) r[1:0] = 2'b00;
    return r;
  endfunction

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [13:0] tag_q, tag_d;
  logic [3:0]  off_q, off_d;
  logic [15:0] wlo_q, wlo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // NOTE: the store is deliberately left out of reset; contents survive RESET and a
  // resettable array this size would not map onto RAM.
  logic [7:0] store_mem [0:(1<<AW)-1];

  logic [AW-1:0] rd_base, wr_base;
  logic [7:0]    rb [4];
  logic [15:0]   word0, word1;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic          c1_oe, d1_oe;
  logic [15:0]   d1_out;

  // Read path: the full line offset is known from ADDR2 onwards.
  always_comb begin
    rd_base = align(cmd_q, AW'({tag_q, off_q}));
    for (int i = 0; i < 4; i++) rb[i] = store_mem[rd_base | AW'(i)];
    word0 = (cmd_q == CMD_RD8) ? {8'h00, rb[0]} : {rb[1], rb[0]};
    word1 = {rb[3], rb[2]};
  end

  // Write path: commit happens on the edge ending T1, using the offset and high
  // data half straight off the bus.
  always_comb begin
    wr_base = align(cmd_q, AW'({tag_q, A1[3:0]}));
    wr_data = {D1, wlo_q};
    case (cmd_q)
      CMD_WR8:  wr_be = 4'b0001;
      CMD_WR16: wr_be = 4'b0011;
      CMD_WR32: wr_be = 4'b1111;
      default:  wr_be = 4'b0000;
    endcase
    wr_en = (state_q == S_ADDR2) && is_write(cmd_q) && !RESET;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) store_mem[wr_base | AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case
    // leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    off_d      = off_q;
    wlo_d      = wlo_q;
    cnt_d      = cnt_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;

    case (state_q)
      S_IDLE: begin
        // X/Z match no item and fall through to the default, keeping us idle.
        case (C1)
          3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7: begin
            cmd_d   = cmd_e'(C1);
            tag_d   = A1;
            wlo_d   = D1;
            state_d = S_ADDR2;
          end
          default: ;
        endcase
      end
      S_ADDR2: begin
        off_d = A1[3:0];
        if (LATENCY <= 1) begin
          state_d = S_RESP0;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_RESP0;
      end
      S_RESP0: begin
        if (cmd_q == CMD_RD32) begin
          state_d = S_RESP1;
        end else begin
          state_d = S_RELEASE;
          if (is_read(cmd_q))       rd_count_d = rd_count_q + 32'd1;
          else if (is_write(cmd_q)) wr_count_d = wr_count_q + 32'd1;
        end
      end
      S_RESP1: begin
        state_d    = S_RELEASE;
        rd_count_d = rd_count_q + 32'd1;
      end
      S_RELEASE: begin
        if (C1 == 3'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_NOP;
      tag_q      <= '0;
      off_q      <= '0;
      wlo_q      <= '0;
      cnt_q      <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every flop samples pre-edge values.
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      off_q      <= off_d;
      wlo_q      <= wlo_d;
      cnt_q      <= cnt_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    c1_oe  = (state_q == S_RESP0) || (state_q == S_RESP1);
    d1_oe  = ((state_q == S_RESP0) && is_read(cmd_q)) || (state_q == S_RESP1);
    d1_out = (state_q == S_RESP1) ? word1 : word0;
  end

  assign C1       = c1_oe ? RESP_CODE : 3'bz;
  assign D1       = d1_oe ? d1_out : 16'bz;
  assign BUSY     = (state_q != S_IDLE);
  assign RD_COUNT = rd_count_q;
  assign WR_COUNT = wr_count_q;

endmodule

// File: tb/tb_cache_bus1_responder.sv
// Scoreboard bench for cache_bus1_responder: one instance at LATENCY=6, one at LATENCY=1.
module tb_cache_bus1_responder;

  localparam int LAT_A = 6;
  localparam int LAT_B = 1;

  typedef enum logic [2:0] {NOP, RD8, RD16, RD32, INV, WR8, WR16, WR32} cmd_e;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [15:0] data;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] a1;
  logic [2:0]  c1_drv;
  logic        c1_en;
  logic [15:0] d1_drv;
  logic        d1_en;
  bit          sel;

  wire [2:0]  c1_a, c1_b;
  wire [15:0] d1_a, d1_b;
  logic        busy_a, busy_b;
  logic [31:0] rdc_a, wrc_a, rdc_b, wrc_b;

  assign c1_a = (c1_en && !sel) ? c1_drv : 3'bz;
  assign c1_b = (c1_en &&  sel) ? c1_drv : 3'bz;
  assign d1_a = (d1_en && !sel) ? d1_drv : 16'bz;
  assign d1_b = (d1_en &&  sel) ? d1_drv : 16'bz;

  cache_bus1_responder #(.LATENCY(LAT_A), .MEM_ADDR_BITS(18)) dut (
    .CLK(clk), .RESET(rst), .A1(a1), .D1(d1_a), .C1(c1_a),
    .BUSY(busy_a), .RD_COUNT(rdc_a), .WR_COUNT(wrc_a)
  );

  cache_bus1_responder #(.LATENCY(LAT_B), .MEM_ADDR_BITS(18)) dut_l1 (
    .CLK(clk), .RESET(rst), .A1(a1), .D1(d1_b), .C1(c1_b),
    .BUSY(busy_b), .RD_COUNT(rdc_b), .WR_COUNT(wrc_b)
  );

  always #5 clk = ~clk;

  // A released bus reads as Z on four-state simulators and 0 on two-state ones.
  wire [2:0]  c1_o = sel ? c1_b : c1_a;
  wire [15:0] d1_o = sel ? d1_b : d1_a;
  wire [2:0]  c1_n = $isunknown(c1_o) ? 3'd0 : c1_o;
  wire [15:0] d1_n = $isunknown(d1_o) ? 16'd0 : d1_o;
  wire        busy_n = sel ? busy_b : busy_a;
  wire [31:0] rdc_n  = sel ? rdc_b : rdc_a;
  wire [31:0] wrc_n  = sel ? wrc_b : wrc_a;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] model [int];
  int   exp_rd [2];
  int   exp_wr [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int key(input logic [17:0] a);
    return (sel ? 32'h40000 : 32'h0) + int'(a);
  endfunction

  function automatic logic [7:0] mb(input logic [17:0] a);
    return model.exists(key(a)) ? model[key(a)] : 8'h00;
  endfunction

  // Every responder cycle (C1=7 while the bench has let go of C1) is matched against
  // the oldest expected response: arrival cycle and D1 content.
  always @(negedge clk) begin
    if (!c1_en && c1_n == 3'd7) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 32'(c1_n), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_cyc"}, 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.rd) check({mon_e.tag, "_data"}, 32'(d1_n), 32'(mon_e.data));
        else          check({mon_e.tag, "_d1z"}, 32'(d1_n), 32'd0);
      end
    end
  end

  task automatic txn(input string tag, input cmd_e cmd, input logic [17:0] addr,
                     input logic [31:0] wdata, input int hold);
    int lat;
    int nresp;
    int t1;
    int nb;
    logic [17:0] b;
    lat   = sel ? LAT_B : LAT_A;
    nresp = (cmd == RD32) ? 2 : 1;
    b = addr;
    if (cmd == RD16 || cmd == WR16) b[0] = 1'b0;
    if (cmd == RD32 || cmd == WR32) b[1:0] = 2'b00;

    tick();  // T0
    a1     = addr[17:4];
    c1_drv = cmd;
    c1_en  = 1'b1;
    d1_drv = wdata[15:0];
    d1_en  = (cmd == WR8 || cmd == WR16 || cmd == WR32);
    t1     = cyc + 1;
    case (cmd)
      RD8:  sb.push_back('{t1 + lat, 1'b1, {8'h00, mb(b)}, tag});
      RD16: sb.push_back('{t1 + lat, 1'b1, {mb(b + 18'd1), mb(b)}, tag});
      RD32: begin
        sb.push_back('{t1 + lat,     1'b1, {mb(b + 18'd1), mb(b)}, {tag, "_w0"}});
        sb.push_back('{t1 + lat + 1, 1'b1, {mb(b + 18'd3), mb(b + 18'd2)}, {tag, "_w1"}});
      end
      default: sb.push_back('{t1 + lat, 1'b0, 16'h0, tag});
    endcase
    nb = (cmd == WR8) ? 1 : (cmd == WR16) ? 2 : (cmd == WR32) ? 4 : 0;
    for (int i = 0; i < nb; i++) model[key(b + 18'(i))] = wdata[8*i +: 8];
    if (cmd == RD8 || cmd == RD16 || cmd == RD32) exp_rd[sel]++;
    if (nb != 0) exp_wr[sel]++;

    tick();  // T1
    check({tag, "_busy_t1"}, 32'(busy_n), 32'd1);
    a1     = {10'h000, addr[3:0]};
    c1_en  = 1'b0;
    d1_drv = wdata[31:16];
    tick();
    d1_en = 1'b0;
    repeat (lat + nresp - 1) tick();

    // First RELEASE cycle: bus let go, counters already stepped.
    check({tag, "_c1_rel"}, 32'(c1_n), 32'd0);
    check({tag, "_d1_rel"}, 32'(d1_n), 32'd0);
    check({tag, "_busy_rel"}, 32'(busy_n), 32'd1);
    check({tag, "_rdc"}, rdc_n, 32'(exp_rd[sel]));
    check({tag, "_wrc"}, wrc_n, 32'(exp_wr[sel]));
    c1_en = 1'b1;
    if (hold > 0) begin
      c1_drv = RD8;
      repeat (hold) begin
        tick();
        check({tag, "_busy_hold"}, 32'(busy_n), 32'd1);
      end
    end
    c1_drv = NOP;
    tick();
    check({tag, "_busy_idle"}, 32'(busy_n), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    a1     = '0;
    c1_drv = NOP;
    c1_en  = 1'b1;
    d1_drv = '0;
    d1_en  = 1'b0;
    sel    = 1'b0;
    exp_rd = '{0, 0};
    exp_wr = '{0, 0};
    repeat (3) tick();
    check("rst_busy", 32'(busy_n), 32'd0);
    check("rst_rdc", rdc_n, 32'd0);
    check("rst_wrc", wrc_n, 32'd0);
    check("rst_d1z", 32'(d1_n), 32'd0);
    rst = 1'b0;
    tick();

    // Preload over the bus, then reset so the counters start from zero.
    txn("pre_10", WR32, 18'h00010, 32'h04030201, 0);
    txn("pre_f04", WR32, 18'h00F04, 32'h77665544, 0);
    rst = 1'b1;
    tick();
    exp_rd = '{0, 0};
    exp_wr = '{0, 0};
    check("clr_rdc", rdc_n, 32'd0);
    check("clr_wrc", wrc_n, 32'd0);
    rst = 1'b0;
    tick();

    txn("rd8_13", RD8, 18'h00013, 32'h0, 0);
    txn("rd32_10", RD32, 18'h00010, 32'h0, 0);
    txn("wr32_f00", WR32, 18'h00F00, 32'h12345678, 0);
    txn("rd16_f00", RD16, 18'h00F00, 32'h0, 0);
    txn("rd16_f03", RD16, 18'h00F03, 32'h0, 0);
    txn("wr8_f05", WR8, 18'h00F05, 32'h0000ABCD, 0);
    txn("rd8_f05", RD8, 18'h00F05, 32'h0, 0);
    txn("rd8_f04", RD8, 18'h00F04, 32'h0, 0);
    txn("rd8_f06", RD8, 18'h00F06, 32'h0, 0);
    txn("inv_f00", INV, 18'h00F00, 32'h0, 0);
    txn("rd32_f00", RD32, 18'h00F02, 32'h0, 0);
    txn("hold", RD8, 18'h00011, 32'h0, 5);
    txn("after_hold", RD8, 18'h00012, 32'h0, 0);
    txn("wr16_11", WR16, 18'h00011, 32'h0000BEEF, 0);
    txn("rd32_13", RD32, 18'h00013, 32'h0, 0);

    // RESET during WAIT of a READ16: the response must never appear.
    tick();
    a1     = 14'h0001;
    c1_drv = RD16;
    c1_en  = 1'b1;
    tick();
    a1    = 14'h0002;
    c1_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_rd = '{0, 0};
    exp_wr = '{0, 0};
    check("abort_busy", 32'(busy_n), 32'd0);
    check("abort_rdc", rdc_n, 32'd0);
    check("abort_wrc", wrc_n, 32'd0);
    rst = 1'b0;
    repeat (LAT_A + 4) tick();
    c1_en  = 1'b1;
    c1_drv = NOP;
    tick();
    txn("rd16_12", RD16, 18'h00012, 32'h0, 0);

    // LATENCY=1 instance: response lands in T2.
    sel = 1'b1;
    tick();
    txn("l1_wr32", WR32, 18'h00020, 32'hCAFEF00D, 0);
    txn("l1_rd16", RD16, 18'h00022, 32'h0, 0);
    txn("l1_rd8", RD8, 18'h00020, 32'h0, 0);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
